// File: rtl/regfile_sync_init_pkg.sv
// Shared widths, constants and clear-sequencer state encodings for regfile_sync_init.
package regfile_sync_init_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int REG_NUM        = 32;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks entries 1..NUM_REGS-1 writing zero, then parks in RUN.
module regfile_init_seq
  import regfile_sync_init_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_BUS_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_busy_q, init_busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    // Registered, so busy drops one edge after the FSM reaches RUN.
    init_busy_d = (state_q == ST_INIT);
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_INIT;
      cnt_q       <= ADDR_W'(1);
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign clr_we    = (state_q == ST_INIT);
  assign clr_addr  = cnt_q;
  assign init_busy = init_busy_q;

endmodule

// File: rtl/regfile_sync_init.sv
// Two-read/one-write register file with write-to-read bypass and a post-reset clear sequence.
// Optional stored even parity with a sticky parity_err output under `REGFILE_PARITY_EN.
module regfile_sync_init
  import regfile_sync_init_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_BUS_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_busy
`ifdef REGFILE_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_init_seq #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              byp1, byp2;
  logic              rd1_ok, rd2_ok;

  // The clear sequencer owns the write port while INIT lasts; external writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = ZERO;
    end else if (we == WRITE_ENABLE && waddr != '0) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: no reset on the array so it maps to RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign rd1_ok = !clr_we && (re1 == READ_ENABLE) && (raddr1 != '0);
  assign rd2_ok = !clr_we && (re2 == READ_ENABLE) && (raddr2 != '0);
  assign byp1   = (we == WRITE_ENABLE) && (waddr == raddr1);
  assign byp2   = (we == WRITE_ENABLE) && (waddr == raddr2);

  always_comb begin
    rdata1 = ZERO;
    if (rd1_ok) begin
      rdata1 = byp1 ? wdata : mem[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZERO;
    if (rd2_ok) begin
      rdata2 = byp2 ? wdata : mem[raddr2];
    end
  end

`ifdef REGFILE_PARITY_EN
  logic par_mem [NUM_REGS];
  logic mem_wpar;
  logic perr1, perr2;
  logic parity_err_q, parity_err_d;

  assign mem_wpar = clr_we ? 1'b0 : ^wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[mem_addr] <= mem_wpar;
    end
  end

  assign perr1 = rd1_ok && !byp1 && ((^mem[raddr1]) != par_mem[raddr1]);
  assign perr2 = rd2_ok && !byp2 && ((^mem[raddr2]) != par_mem[raddr2]);

  always_comb begin
    parity_err_d = parity_err_q | perr1 | perr2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_regfile_sync_init.sv
// Directed self-checking bench for regfile_sync_init; parity checks build with REGFILE_PARITY_EN.
module tb_regfile_sync_init;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_busy;
`ifdef REGFILE_PARITY_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sync_init dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .init_busy (init_busy)
`ifdef REGFILE_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    repeat (3) @(negedge clk);

    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    check("reset_busy", {31'd0, init_busy}, 32'd1);
    check("reset_rdata1", rdata1, 32'd0);

    // Release during a write attempt to r5 that must be dropped.
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("init_busy_%0d", i), {31'd0, init_busy}, 32'd1);
      check($sformatf("init_rdata1_%0d", i), rdata1, 32'd0);
      if (i == 30) we = 1'b0;
    end
    tick();
    check("busy_fall_32", {31'd0, init_busy}, 32'd0);
    check("r5_write_dropped", rdata1, 32'd0);

    // Plain write then read on the following cycle.
    re1 = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
    #1 check("r3_read", rdata1, 32'h1234_5678);
    re1 = 1'b0;
    #1 check("r3_re_off", rdata1, 32'd0);

    // Bypass hit on both ports, then array hit.
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    check("r7_byp_p1", rdata1, 32'hA5A5_A5A5);
    check("r7_byp_p2", rdata2, 32'hA5A5_A5A5);
    tick();
    we = 1'b0;
    #1;
    check("r7_arr_p1", rdata1, 32'hA5A5_A5A5);
    check("r7_arr_p2", rdata2, 32'hA5A5_A5A5);

    // r0 stays zero, even while a write to it is in flight.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("r0_byp_p1", rdata1, 32'd0);
    check("r0_byp_p2", rdata2, 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("r0_arr_p1", rdata1, 32'd0);
    check("r0_arr_p2", rdata2, 32'd0);

    // Fill r1..r31, then reset in RUN and again mid-INIT.
    re1 = 1'b0; re2 = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'hC000_0000 | 32'(i);
      tick();
    end
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd17;
    #1 check("fill_r17", rdata1, 32'hC000_0011);

    rst = 1'b0;
    #1;
    check("rst_run_busy", {31'd0, init_busy}, 32'd1);
    check("rst_run_rdata1", rdata1, 32'd0);
    #2 rst = 1'b1;
    repeat (10) tick();
    check("mid_init_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b0;
    #1 check("rst_init_busy", {31'd0, init_busy}, 32'd1);
    #2 rst = 1'b1;
    repeat (31) tick();
    check("restart_busy_31", {31'd0, init_busy}, 32'd1);
    tick();
    check("restart_busy_32", {31'd0, init_busy}, 32'd0);
    re2 = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      check($sformatf("clr_p1_r%0d", i), rdata1, 32'd0);
      check($sformatf("clr_p2_r%0d", i), rdata2, 32'd0);
    end

`ifdef REGFILE_PARITY_EN
    re1 = 1'b0; re2 = 1'b0;
    check("par_clean", {31'd0, parity_err}, 32'd0);
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0001;
    tick();
    we = 1'b0;
    dut.par_mem[9] = ~dut.par_mem[9];
    // Bypassed read must not flag; the write also restores correct parity.
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0001; re1 = 1'b1; raddr1 = 5'd9;
    #1 check("par_byp_data", rdata1, 32'h0000_0001);
    tick();
    check("par_byp_noset", {31'd0, parity_err}, 32'd0);
    we = 1'b0;
    dut.par_mem[9] = ~dut.par_mem[9];
    #1 check("par_data_unaffected", rdata1, 32'h0000_0001);
    tick();
    check("par_err_set", {31'd0, parity_err}, 32'd1);
    re1 = 1'b0;
    repeat (3) tick();
    check("par_err_sticky", {31'd0, parity_err}, 32'd1);
    rst = 1'b0;
    #1 check("par_err_rst", {31'd0, parity_err}, 32'd0);
    #2 rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sync_init.md
Name: regfile_sync_init

Overview:
- General-purpose register file serving the decode stage's two operand-read ports and the write-back stage's single write port.
- Read ports answer reg1/reg2 read-enable and address requests combinationally within the same cycle.
- Same-cycle write-to-read bypass is built in.
- Storage is a RAM-inferable array without per-entry reset. A post-reset clear sequencer zeroes it and holds `init_busy` high until done; the pipeline stalls on `init_busy`.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; entry 0 is hardwired to zero.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- we  input  1  write enable from write-back stage.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- re1  input  1  read-port-1 enable.
- raddr1  input  ADDR_W  read-port-1 address.
- rdata1  output  DATA_W  read-port-1 data, combinational.
- re2  input  1  read-port-2 enable.
- raddr2  input  ADDR_W  read-port-2 address.
- rdata2  output  DATA_W  read-port-2 data, combinational.
- init_busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM forced to INIT; clear counter forced to 1; init_busy = 1.
  - Array contents are not reset directly.
  - rdata1/rdata2 = 0 for as long as INIT lasts.
- FSM states:
  - INIT: each cycle writes 0 to entry[counter]; counter increments.
    - When counter == NUM_REGS-1, that entry is cleared and the FSM goes to RUN on the same edge.
    - Release of rst to first RUN cycle takes exactly 31 clocks; init_busy falls on the 32nd rising edge after release.
  - RUN: terminal state; only left via rst.
- Reset mid-INIT or mid-RUN: FSM returns to INIT and the clear sequence restarts from entry 1.
- Writes:
  - In RUN, on a clock edge with we=1 and waddr != 0, entry[waddr] <= wdata.
  - Writes to address 0 are discarded.
  - During INIT, external writes are dropped; no queuing.
- Reads (per port n, pure combinational), in priority order:
  1. INIT -> 0
  2. ren=0 -> 0
  3. raddrn=0 -> 0
  4. we=1 and waddr==raddrn -> wdata (bypass)
  5. otherwise -> entry[raddrn]
- Both ports may read the same address, with or without a bypass hit, in the same cycle; both return identical data.
- No read latency. Write is visible to a read in the same cycle via bypass and from the array in the next cycle.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- When defined:
  - Each entry stores an extra even-parity bit computed from wdata at write time; INIT writes parity 0.
  - Extra output `parity_err` (1 bit) is added; reset value 0.
  - parity_err sets on any enabled read in RUN of a nonzero, non-bypassed address whose stored parity mismatches its data.
  - parity_err is sticky until rst.
  - Read data is unaffected.
- When undefined: no parity storage, no parity_err port; behaviour otherwise identical.

Decomposition:
- Shared defines/package:
  - RegBus, RegAddrBus widths.
  - ZeroWord.
  - RstEnable, defined here as 1'b0 to match active-low.
  - WriteEnable, ReadEnable.
  - RegNum (32).
  - FSM state encodings INIT, RUN.
- One sub-module: `regfile_init_seq`. It holds the INIT/RUN FSM and clear counter and outputs clr_we, clr_addr and init_busy. The top muxes clr_we/clr_addr against the external write port.

Test Plan:
- Release rst, hold we=1/waddr=5/wdata=32'hDEAD_BEEF during INIT -> init_busy high for 31 cycles; rdata1=0 throughout; after RUN, read r5 returns 0 (write dropped).
- In RUN, write r3=32'h1234_5678, next cycle re1=1/raddr1=3 -> rdata1=32'h1234_5678; re1=0 -> rdata1=0.
- Same cycle we=1/waddr=7/wdata=32'hA5A5_A5A5 with re1=re2=1, raddr1=raddr2=7 -> both rdata=32'hA5A5_A5A5 (bypass); following cycle still 32'hA5A5_A5A5 from array.
- Write r0=32'hFFFF_FFFF, then read r0 on both ports, including the bypass cycle -> 0 every time.
- Fill r1..r31 with nonzero values, pulse rst low mid-INIT at cycle 10 and again in RUN -> init_busy reasserts; sequence restarts; all r1..r31 read 0 after 31 cycles.
- (REGFILE_PARITY_EN) Write r9=32'h0000_0001, force-flip stored parity via bench backdoor, read r9 -> parity_err=1 next evaluation and stays 1 until rst; bypassed read of r9 does not set it.
